// File: rtl/if_prefetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_buffer
//  Purpose  : Instruction prefetch queue sitting between the instruction
//             memory port and the fetch stage. Issues sequential word fetches
//             ahead of the pipeline, stores in-order responses tagged with
//             their PC, and presents them over a valid/ready handshake.
//             A redirect flushes the queue and discards responses that are
//             still in flight for the abandoned path.
//
//  Ports    : clk, rst_n           - core clock, async active-low reset
//             imem_req_*           - fetch request (valid/addr/ready)
//             imem_resp_*          - in-order fetch responses (latency >= 1)
//             inst_valid_o/pc/data - head instruction towards the fetch stage
//             inst_ready_i         - fetch stage consumes the head entry
//             redirect_i/_pc_i     - taken branch/jump: flush and refetch
//             perf_starve_cnt_o    - (IF_PREFETCH_PERF_EN only) saturating
//                                    count of cycles the fetch stage wanted
//                                    an instruction and none was available
//
//  Options  : IF_PREFETCH_PERF_EN  - adds the starvation performance counter
//
//  Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_buffer #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid_o,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_req_ready_i,
    input  logic                  imem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] imem_resp_data_i,
    output logic                  inst_valid_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic [DATA_WIDTH-1:0] inst_data_o,
    input  logic                  inst_ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]           perf_starve_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W:0]        c_depth    = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W:0]        c_wide_one = (CNT_W + 1)'(1);
    localparam logic [PTR_W-1:0]      c_ptr_one  = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_pc_step  = ADDR_WIDTH'(4);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [DEPTH-1:0]      r_filled;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W-1:0]      r_fill;
    logic [CNT_W-1:0]      r_count;        // allocated entries
    logic [CNT_W-1:0]      r_outstanding;  // allocated entries still awaiting data
    logic [CNT_W-1:0]      r_drop_cnt;     // stale responses still owed
    logic [0:0]            r_state;
    logic [0:0]            w_state_next;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [CNT_W:0]   w_credit_used;
    logic             w_req_valid;
    logic             w_issue;
    logic             w_head_valid;
    logic             w_pop;
    logic             w_discard;
    logic             w_resp_drop;
    logic             w_resp_accept;
    logic [CNT_W:0]   w_inflight;
    logic [CNT_W:0]   w_drop_sum;
    logic [CNT_W-1:0] w_drop_redirect;

    // Credit covers both live entries and responses owed from a flushed
    // path, so a stale response can never land in a freshly allocated slot.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_drop_cnt};
    // rst_n gates the request so nothing is offered while reset is held.
    assign w_req_valid   = rst_n && !redirect_i && (w_credit_used < c_depth);
    assign w_issue       = w_req_valid && imem_req_ready_i;

    assign w_head_valid  = (r_count != '0) && r_filled[r_head];
    assign w_pop         = w_head_valid && inst_ready_i && !redirect_i;

    assign w_resp_drop   = imem_resp_valid_i && w_discard;
    assign w_resp_accept = imem_resp_valid_i && !w_discard && (r_outstanding != '0);

    // Everything in flight at redirect becomes owed-and-dropped; a response
    // arriving in the redirect cycle itself is consumed now.
    assign w_inflight      = {1'b0, r_outstanding} + {1'b0, r_drop_cnt};
    assign w_drop_sum      = (imem_resp_valid_i && (w_inflight != '0)) ?
                             (w_inflight - c_wide_one) : w_inflight;
    assign w_drop_redirect = w_drop_sum[CNT_W-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (redirect_i) begin
            w_state_next = (w_drop_redirect != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_RUN:   w_state_next = S_RUN;
                S_DRAIN: begin
                    if (w_resp_drop && (r_drop_cnt == c_cnt_one)) begin
                        w_state_next = S_RUN;
                    end
                end
                default: w_state_next = S_RUN;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        w_discard = 1'b0;
        case (r_state)
            S_RUN:   w_discard = 1'b0;
            S_DRAIN: w_discard = 1'b1;
            default: w_discard = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue storage, pointers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_filled      <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]   <= '0;
                r_data_mem[i] <= '0;
            end
        end else if (redirect_i) begin
            r_fetch_pc    <= redirect_pc_i;
            r_filled      <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_fill        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= w_drop_redirect;
        end else begin
            // Issue and accept never touch the same slot: fill == tail only
            // when nothing is outstanding, in which case no accept occurs.
            if (w_issue) begin
                r_pc_mem[r_tail] <= r_fetch_pc;
                r_filled[r_tail] <= 1'b0;
                r_tail           <= r_tail + c_ptr_one;
                r_fetch_pc       <= r_fetch_pc + c_pc_step;
            end
            if (w_resp_accept) begin
                r_data_mem[r_fill] <= imem_resp_data_i;
                r_filled[r_fill]   <= 1'b1;
                r_fill             <= r_fill + c_ptr_one;
            end
            if (w_resp_drop) begin
                r_drop_cnt <= r_drop_cnt - c_cnt_one;
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_one;
            end

            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase

            case ({w_issue, w_resp_accept})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
                2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (head data forced to zero when no instruction is offered)
    // ------------------------------------------------------------------
    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_fetch_pc;
    assign inst_valid_o     = w_head_valid;
    assign inst_pc_o        = w_head_valid ? r_pc_mem[r_head]   : '0;
    assign inst_data_o      = w_head_valid ? r_data_mem[r_head] : '0;

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] r_perf_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_starve <= '0;
        end else if (inst_ready_i && !w_head_valid && !redirect_i &&
                     (r_perf_starve != 32'hFFFF_FFFF)) begin
            r_perf_starve <= r_perf_starve + 32'd1;
        end
    end

    assign perf_starve_cnt_o = r_perf_starve;
`endif

    // ------------------------------------------------------------------
    // Simulation checks
    // ------------------------------------------------------------------
    // A response with neither an owed drop nor an allocated slot is ignored.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
        imem_resp_valid_i |-> ((r_drop_cnt != '0) || (r_outstanding != '0)));

    // DRAIN exactly tracks "stale responses still owed".
    a_drain_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == S_DRAIN) == (r_drop_cnt != '0));

endmodule
`default_nettype wire

// File: doc/if_prefetch_buffer.md
# if_prefetch_buffer

Instruction prefetch queue between the instruction memory port and `IF_stage`. It issues sequential fetch requests ahead of the pipeline and buffers in-order responses tagged with their PC. It hands instructions to the fetch stage over a valid/ready handshake and discards stale in-flight responses on a control-flow redirect from EX.

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, ≥2.
- `ADDR_WIDTH`, 32: PC / fetch address width.
- `DATA_WIDTH`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_req_valid_o`  out  1  fetch request valid.
- `imem_req_addr_o`  out  ADDR_WIDTH  fetch address, word aligned.
- `imem_req_ready_i`  in  1  memory accepts request.
- `imem_resp_valid_i`  in  1  response data valid; responses return in request order, latency ≥1 cycle.
- `imem_resp_data_i`  in  DATA_WIDTH  returned instruction.
- `inst_valid_o`  out  1  head entry holds an instruction.
- `inst_pc_o`  out  ADDR_WIDTH  PC of head instruction.
- `inst_data_o`  out  DATA_WIDTH  head instruction.
- `inst_ready_i`  in  1  fetch stage consumes head; `pc_we` from the core maps here.
- `redirect_i`  in  1  branch/jump taken; flush.
- `redirect_pc_i`  in  ADDR_WIDTH  new fetch target.

## Operation
- State: `fetch_pc`, circular FIFO (pc, data, filled flag per entry), `head`/`tail`/`fill` pointers, `count` (allocated entries), `drop_cnt` (stale responses still owed). Counters are $clog2(DEPTH+1) bits wide.
- Slot allocated at issue: on `req_valid && req_ready`, write `fetch_pc` into `tail`, clear filled, `tail++`, `count++`, `fetch_pc += 4`. The add is modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC wraps to 0.
- `imem_req_valid_o = !redirect_i && (count + drop_cnt) < DEPTH`, computed from registered state plus `redirect_i` only. There is no path from `inst_ready_i`.
- Response handling: if `drop_cnt != 0`, discard the response and decrement. Otherwise write data into entry `fill`, set filled, `fill++`.
- Pop: `inst_valid_o && inst_ready_i` → `head++`, `count--`. `inst_valid_o` = filled flag of `head` when `count != 0`.
- FSM: RUN ↔ DRAIN.
  - RUN: normal operation.
  - Redirect from either state → DRAIN if in-flight after this cycle > 0, else RUN.
  - DRAIN → RUN when `drop_cnt` reaches 0 with no new redirect.
  - Requests are still issued in DRAIN within credit.
- Redirect: clear all entries and pointers, `count ← 0`, `fetch_pc ← redirect_pc_i`. Set `drop_cnt` ← (allocated-but-unfilled entries + existing `drop_cnt`), minus 1 if a response arrives this cycle. A pop in the same cycle is ignored.
- Response with no owed/allocated slot: ignored; simulation assertion fires.

## Timing
- Reset values:
  - `imem_req_valid_o` = 0 while `rst_n` is low; `imem_req_addr_o` = RESET_PC.
  - `inst_valid_o` = 0, `inst_pc_o` = 0, `inst_data_o` = 0.
  - State = RUN; all counters 0.
- First request: first rising edge after `rst_n` deasserts.
- Response on cycle N → `inst_valid_o` on N+1 (registered storage). Zero-latency bypass is not supported.
- Redirect on cycle N → `inst_valid_o` = 0 on N+1. The request to `redirect_pc_i` is offered on N+1.
- Full (`count + drop_cnt == DEPTH`): no request. A pop on cycle N frees credit for N+1.
- Simultaneous issue, response and pop are all legal in one cycle. `count` updates by net +1/0/−1.
- Reset asserted mid-flight: everything cleared immediately. Memory-side responses are the environment's responsibility to quash.

## Configuration
- `IF_PREFETCH_PERF_EN` defined: adds output `perf_starve_cnt_o`, 32 bits.
  - Increments every cycle with `inst_ready_i && !inst_valid_o && !redirect_i`.
  - Saturates at 0xFFFF_FFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

## Test plan
- Reset release, memory ready always, latency 1 → requests 0x0,0x4,0x8,…; `inst_pc_o` 0x0 on cycle 2, then one instruction per cycle with `inst_ready_i` = 1.
- `inst_ready_i` = 0, DEPTH 4 → exactly 4 requests issued (0x0–0xC), then `imem_req_valid_o` = 0. One pop → request 0x10 the next cycle.
- Latency 3, redirect to 0x100 while 3 requests are outstanding → next 3 responses discarded; `drop_cnt` 3→0; first delivered `inst_pc_o` = 0x100 with correct data.
- Redirect in the same cycle as a response and a pop → no stale instruction delivered; `drop_cnt` equals outstanding minus 1.
- `RESET_PC` = 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With `IF_PREFETCH_PERF_EN`, memory ready held low 10 cycles with `inst_ready_i` = 1 → `perf_starve_cnt_o` = 10.
